// File: rtl/key_cmd_pkg.sv
// Shared command codes, per-key FSM state type and the fixed-priority
// key-to-command encoder used by key_command_unit.
package key_cmd_pkg;

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] CMD_NONE    = 2'd0;
  localparam logic [1:0] CMD_SLOWER  = 2'd1;
  localparam logic [1:0] CMD_FASTER  = 2'd2;
  localparam logic [1:0] CMD_DEFAULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  // KEY0 wins over KEY1 over KEY2, matching the sequencer's own priority.
  function automatic logic [1:0] encode_cmd(input logic [2:0] pulse);
    logic [1:0] code;
    if (pulse[0]) begin
      code = CMD_SLOWER;
    end else if (pulse[1]) begin
      code = CMD_FASTER;
    end else if (pulse[2]) begin
      code = CMD_DEFAULT;
    end else begin
      code = CMD_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: two-flop synchroniser, debounce counter, and the
// press/auto-repeat FSM producing registered level and one-cycle pulse.
module key_channel
  import key_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 12_500_000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             pulse_q, pulse_d;
  logic             pressed_s;

  // Synchroniser resets to "released" so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Debounce and repeat-FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= CNT_ZERO;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      rpt_cnt_q <= CNT_ZERO;
      pulse_q   <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  // Synchroniser shift and debounce: level flips only after a full
  // DEBOUNCE_CYCLES run of disagreement; any agreement restarts the count.
  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    pressed_s = ~sync2_q;
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    if (pressed_s == level_q) begin
      db_cnt_d = CNT_ZERO;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = CNT_ZERO;
      level_d  = ~level_q;
    end else begin
      db_cnt_d = db_cnt_q + CNT_ONE;
    end
  end

  // Press / auto-repeat FSM. Decisions use level_d so the press pulse is
  // registered alongside the level, and a release suppresses a due repeat.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    pulse_d   = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_cnt_d = CNT_ZERO;
        if (level_d && !level_q) begin
          state_d = DELAY;
          pulse_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (!level_d) begin
          state_d   = IDLE;
          rpt_cnt_d = CNT_ZERO;
        end else if (!REPEAT_EN) begin
          rpt_cnt_d = CNT_ZERO;
        end else if (rpt_cnt_q == RD_LAST) begin
          state_d   = REPEAT;
          rpt_cnt_d = CNT_ZERO;
          pulse_d   = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!level_d) begin
          state_d   = IDLE;
          rpt_cnt_d = CNT_ZERO;
        end else if (rpt_cnt_q == RP_LAST) begin
          rpt_cnt_d = CNT_ZERO;
          pulse_d   = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = CNT_ZERO;
      end
    endcase
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/key_command_unit.sv
// Three debounced key channels feeding a registered fixed-priority encoder
// that turns press/repeat pulses into single-cycle speed commands.
module key_command_unit
  import key_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 12_500_000,
  parameter logic [2:0]  REPEAT_EN       = 3'b011
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [2:0] KEY,
  output logic [2:0] key_level,
  output logic [2:0] key_pulse,
  output logic       cmd_valid,
  output logic [1:0] cmd_code
);

  logic [2:0] level_s;
  logic [2:0] pulse_s;
  logic       cmd_valid_q, cmd_valid_d;
  logic [1:0] cmd_code_q, cmd_code_d;

  for (genvar i = 0; i < 3; i++) begin : gen_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_EN[i])
    ) u_key (
      .clk  (CLOCK_50),
      .rst_n(RESET_N),
      .key_n(KEY[i]),
      .level(level_s[i]),
      .pulse(pulse_s[i])
    );
  end

  // Lower-priority simultaneous presses are dropped here but stay on key_pulse.
  always_comb begin
    cmd_valid_d = |pulse_s;
    cmd_code_d  = encode_cmd(pulse_s);
  end

  // Command output register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NONE;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign key_level = level_s;
  assign key_pulse = pulse_s;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;

endmodule
